// File: rtl/ecc_perf_pkg.sv
`default_nettype none
// ============================================================================
// ecc_perf_pkg -- snapshot FSM states and per-channel counter-triple type
// Rev 1.0
// ============================================================================
package ecc_perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COPY = 2'd1,
        ST_ACK  = 2'd2
    } snap_state_t;

    // One channel's counter triple, carried as per-cycle increment strobes
    typedef struct packed {
        logic words;
        logic corrected;
        logic dbl;
    } cnt_triple_t;

endpackage
`default_nettype wire

// File: rtl/ecc_sat_counter.sv
`default_nettype none
// ============================================================================
// ecc_sat_counter -- saturating up-counter; clr loads 0 plus this cycle's inc
// Rev 1.0
// ============================================================================
module ecc_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] r_cnt;
    logic         w_max;

    assign w_max = &r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= W'(inc);
        end else if (inc && !w_max) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;
    assign sat = w_max;

endmodule
`default_nettype wire

// File: rtl/ecc_perf_counters_mc.sv
`default_nettype none
// ============================================================================
// ecc_perf_counters_mc -- per-channel ECC word/error counters with snapshot
// read-out; define ECC_PERF_IRQ_EN to add the thresh/irq interrupt. Rev 1.0
// ============================================================================
module ecc_perf_counters_mc
    import ecc_perf_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 32,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] valid,
    input  logic [NUM_CH-1:0] single_error,
    input  logic [NUM_CH-1:0] double_error,
    input  logic              snap_req,
    input  logic              snap_clr,
    input  logic [CH_W-1:0]   rd_ch,
`ifdef ECC_PERF_IRQ_EN
    input  logic [CNT_W-1:0]  thresh,
    output logic              irq,
`endif
    output logic              snap_ack,
    output logic [CNT_W-1:0]  total_words,
    output logic [CNT_W-1:0]  corrected_errors,
    output logic [CNT_W-1:0]  double_errors,
    output logic              sat
);

    cnt_triple_t       w_inc [NUM_CH];
    logic [CNT_W-1:0]  w_words [NUM_CH];
    logic [CNT_W-1:0]  w_corr  [NUM_CH];
    logic [CNT_W-1:0]  w_dbl   [NUM_CH];
    logic [NUM_CH-1:0] w_sat_words;
    logic [NUM_CH-1:0] w_sat_corr;
    logic [NUM_CH-1:0] w_sat_dbl;
    logic              w_copy;
    logic              w_live_clr;
    logic              w_any_sat;

    snap_state_t       r_state;
    logic              r_clr_lat;
    logic              r_snap_ack;
    logic              r_sat;

    logic [CNT_W-1:0]  r_sh_words [NUM_CH];
    logic [CNT_W-1:0]  r_sh_corr  [NUM_CH];
    logic [CNT_W-1:0]  r_sh_dbl   [NUM_CH];
    logic [CNT_W-1:0]  w_rd_words;
    logic [CNT_W-1:0]  w_rd_corr;
    logic [CNT_W-1:0]  w_rd_dbl;
    logic [CNT_W-1:0]  r_total_words;
    logic [CNT_W-1:0]  r_corrected_errors;
    logic [CNT_W-1:0]  r_double_errors;

`ifdef ECC_PERF_IRQ_EN
    logic [NUM_CH-1:0] w_over;
    logic              r_irq;
`endif

    // The clear lands on the same edge that copies live values into the shadows
    assign w_copy     = (r_state == ST_COPY);
    assign w_live_clr = w_copy & r_clr_lat;
    assign w_any_sat  = (|w_sat_words) | (|w_sat_corr) | (|w_sat_dbl);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_inc[i].words     = valid[i];
            assign w_inc[i].dbl       = valid[i] & double_error[i];
            assign w_inc[i].corrected = valid[i] & single_error[i] & ~double_error[i];

            ecc_sat_counter #(.W(CNT_W)) u_words (
                .clk   (clk),
                .reset (reset),
                .inc   (w_inc[i].words),
                .clr   (w_live_clr),
                .cnt   (w_words[i]),
                .sat   (w_sat_words[i])
            );

            ecc_sat_counter #(.W(CNT_W)) u_corr (
                .clk   (clk),
                .reset (reset),
                .inc   (w_inc[i].corrected),
                .clr   (w_live_clr),
                .cnt   (w_corr[i]),
                .sat   (w_sat_corr[i])
            );

            ecc_sat_counter #(.W(CNT_W)) u_dbl (
                .clk   (clk),
                .reset (reset),
                .inc   (w_inc[i].dbl),
                .clr   (w_live_clr),
                .cnt   (w_dbl[i]),
                .sat   (w_sat_dbl[i])
            );

`ifdef ECC_PERF_IRQ_EN
            assign w_over[i] = (w_corr[i] >= thresh);
`endif
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_clr_lat  <= 1'b0;
            r_snap_ack <= 1'b0;
        end else begin
            r_snap_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (snap_req) begin
                        r_state   <= ST_COPY;
                        r_clr_lat <= snap_clr;
                    end
                end
                ST_COPY: begin
                    r_state    <= ST_ACK;
                    r_snap_ack <= 1'b1;
                end
                ST_ACK:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_sh_words[i] <= '0;
                r_sh_corr[i]  <= '0;
                r_sh_dbl[i]   <= '0;
            end
        end else if (w_copy) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_sh_words[i] <= w_words[i];
                r_sh_corr[i]  <= w_corr[i];
                r_sh_dbl[i]   <= w_dbl[i];
            end
        end
    end

    // Unmatched selects (rd_ch >= NUM_CH) fall through to zero
    always_comb begin
        w_rd_words = '0;
        w_rd_corr  = '0;
        w_rd_dbl   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                w_rd_words = r_sh_words[i];
                w_rd_corr  = r_sh_corr[i];
                w_rd_dbl   = r_sh_dbl[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_total_words      <= '0;
            r_corrected_errors <= '0;
            r_double_errors    <= '0;
            r_sat              <= 1'b0;
        end else begin
            r_total_words      <= w_rd_words;
            r_corrected_errors <= w_rd_corr;
            r_double_errors    <= w_rd_dbl;
            r_sat              <= w_live_clr ? 1'b0 : (r_sat | w_any_sat);
        end
    end

`ifdef ECC_PERF_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else if (w_live_clr) begin
            r_irq <= 1'b0;
        end else if ((thresh != '0) && (|w_over)) begin
            r_irq <= 1'b1;
        end
    end

    assign irq = r_irq;
`endif

    assign snap_ack         = r_snap_ack;
    assign total_words      = r_total_words;
    assign corrected_errors = r_corrected_errors;
    assign double_errors    = r_double_errors;
    assign sat              = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_ecc_perf_counters_mc.sv
`default_nettype none
// ============================================================================
// tb_ecc_perf_counters_mc -- scoreboard bench with a behavioural counter model
// Rev 1.0
// ============================================================================
module tb_ecc_perf_counters_mc;

    localparam int NUM_CH = 5;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 3;
    localparam int MAXV   = 255;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_CH-1:0] valid = '0;
    logic [NUM_CH-1:0] single_error = '0;
    logic [NUM_CH-1:0] double_error = '0;
    logic              snap_req = 1'b0;
    logic              snap_clr = 1'b0;
    logic [CH_W-1:0]   rd_ch = '0;
    logic              snap_ack;
    logic [CNT_W-1:0]  total_words;
    logic [CNT_W-1:0]  corrected_errors;
    logic [CNT_W-1:0]  double_errors;
    logic              sat;
`ifdef ECC_PERF_IRQ_EN
    logic [CNT_W-1:0]  thresh = '0;
    logic              irq;
`endif

    ecc_perf_counters_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) u_dut (
        .clk              (clk),
        .reset            (reset),
        .valid            (valid),
        .single_error     (single_error),
        .double_error     (double_error),
        .snap_req         (snap_req),
        .snap_clr         (snap_clr),
        .rd_ch            (rd_ch),
`ifdef ECC_PERF_IRQ_EN
        .thresh           (thresh),
        .irq              (irq),
`endif
        .snap_ack         (snap_ack),
        .total_words      (total_words),
        .corrected_errors (corrected_errors),
        .double_errors    (double_errors),
        .sat              (sat)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ack_cnt = 0;

    typedef struct {
        int ch;
        int w;
        int c;
        int d;
        int s;
    } rd_exp_t;

    rd_exp_t q[$];
    rd_exp_t mon_e;
    logic    rd_strobe   = 1'b0;
    logic    rd_strobe_d = 1'b0;

    // Behavioural model: live counts, shadow copies, sticky saturation, snapshot phase
    int m_w [NUM_CH];
    int m_c [NUM_CH];
    int m_d [NUM_CH];
    int s_w [NUM_CH];
    int s_c [NUM_CH];
    int s_d [NUM_CH];
    int m_sat;
    int m_phase;
    int m_clr;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sinc(input int v);
        return (v < MAXV) ? v + 1 : MAXV;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_w[i] = 0; m_c[i] = 0; m_d[i] = 0;
            s_w[i] = 0; s_c[i] = 0; s_d[i] = 0;
        end
        m_sat = 0; m_phase = 0; m_clr = 0;
    endtask

    task automatic model_update(input logic [NUM_CH-1:0] v, se, de, input bit req, clr);
        if (m_phase == 1) begin
            for (int i = 0; i < NUM_CH; i++) begin
                s_w[i] = m_w[i]; s_c[i] = m_c[i]; s_d[i] = m_d[i];
                if (m_clr != 0) begin
                    m_w[i] = 0; m_c[i] = 0; m_d[i] = 0;
                end
            end
            if (m_clr != 0) m_sat = 0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (v[i]) begin
                m_w[i] = sinc(m_w[i]);
                if (de[i])      m_d[i] = sinc(m_d[i]);
                else if (se[i]) m_c[i] = sinc(m_c[i]);
            end
            if (m_w[i] == MAXV || m_c[i] == MAXV || m_d[i] == MAXV) m_sat = 1;
        end
        case (m_phase)
            0: if (req) begin m_phase = 1; m_clr = clr ? 1 : 0; end
            1: m_phase = 2;
            default: m_phase = 0;
        endcase
    endtask

    // One clock cycle: drive at +1 after the edge, check snap_ack at the falling edge
    task automatic step(input logic [NUM_CH-1:0] v, se, de, input bit req, clr);
        bit exp_ack;
        valid = v; single_error = se; double_error = de;
        snap_req = req; snap_clr = clr;
        exp_ack = (m_phase == 2);
        @(negedge clk);
        chk("snap_ack", snap_ack, exp_ack);
        model_update(v, se, de, req, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic snap(input bit clr, input logic [NUM_CH-1:0] cv, cse, cde);
        step('0, '0, '0, 1'b1, clr);
        step(cv, cse, cde, 1'b0, 1'b0);
        idle(2);
    endtask

    task automatic read_exp(input int ch, w, c, d, s);
        rd_exp_t e;
        e.ch = ch; e.w = w; e.c = c; e.d = d; e.s = s;
        rd_ch = CH_W'(ch);
        rd_strobe = 1'b1;
        q.push_back(e);
        step('0, '0, '0, 1'b0, 1'b0);
        rd_strobe = 1'b0;
    endtask

    task automatic read_all_model();
        for (int ch = 0; ch < 8; ch++) begin
            if (ch < NUM_CH) read_exp(ch, s_w[ch], s_c[ch], s_d[ch], m_sat);
            else             read_exp(ch, 0, 0, 0, m_sat);
        end
        idle(2);
    endtask

    always @(posedge clk) rd_strobe_d <= rd_strobe;

    always @(negedge clk) begin
        if (snap_ack) ack_cnt++;
        if (rd_strobe_d) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_pop: read output with empty queue, got %0d expected none", total_words);
            end else begin
                mon_e = q.pop_front();
                chk($sformatf("rd_words ch%0d", mon_e.ch), total_words, mon_e.w);
                chk($sformatf("rd_corr ch%0d", mon_e.ch), corrected_errors, mon_e.c);
                chk($sformatf("rd_dbl ch%0d", mon_e.ch), double_errors, mon_e.d);
                chk($sformatf("rd_sat ch%0d", mon_e.ch), sat, mon_e.s);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_words", total_words, 0);
        chk("rst_corr", corrected_errors, 0);
        chk("rst_dbl", double_errors, 0);
        chk("rst_sat", sat, 0);
        chk("rst_ack", snap_ack, 0);
`ifdef ECC_PERF_IRQ_EN
        chk("rst_irq", irq, 0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        idle(2);

        // ch0: 4 clean, 3 single, 2 double, 1 single+double; flags ignored when not valid
        for (int k = 0; k < 10; k++) begin
            step(5'b00001,
                 ((k >= 4 && k < 7) || k == 9) ? 5'b00001 : 5'b00000,
                 (k >= 7) ? 5'b00001 : 5'b00000, 1'b0, 1'b0);
        end
        step('0, 5'b00001, 5'b00001, 1'b0, 1'b0);
        snap(1'b0, '0, '0, '0);
        read_exp(0, 10, 3, 3, 0);

        // ch1: 300 words into an 8-bit counter saturates without wrapping
        for (int k = 0; k < 300; k++) step(5'b00010, '0, '0, 1'b0, 1'b0);
        snap(1'b0, '0, '0, '0);
        read_exp(1, 255, 0, 0, 1);
        read_exp(0, 10, 3, 3, 1);

        // ch2: clearing snapshot with a word arriving during COPY
        for (int k = 0; k < 7; k++) step(5'b00100, '0, '0, 1'b0, 1'b0);
        snap(1'b1, 5'b00100, '0, '0);
        read_exp(2, 7, 0, 0, 0);
        read_exp(1, 255, 0, 0, 0);
        read_exp(0, 10, 3, 3, 0);
        snap(1'b0, '0, '0, '0);
        read_exp(2, 1, 0, 0, 0);
        read_exp(1, 0, 0, 0, 0);
        read_exp(5, 0, 0, 0, 0);
        read_exp(7, 0, 0, 0, 0);
        idle(2);

        // snap_req held for three cycles yields exactly one acknowledge
        a0 = ack_cnt;
        step('0, '0, '0, 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b0);
        step('0, '0, '0, 1'b1, 1'b0);
        idle(3);
        chk("ack_once", ack_cnt - a0, 1);

        // Randomized traffic with stray snapshot requests, then a full read-back
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 40; k++) begin
                step(NUM_CH'($urandom), NUM_CH'($urandom), NUM_CH'($urandom),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
            end
            idle(3);
            snap(($urandom_range(0, 1) == 1), NUM_CH'($urandom), NUM_CH'($urandom),
                 NUM_CH'($urandom));
            read_all_model();
        end

        // Reset in the middle of COPY abandons the snapshot
        rd_ch = '0;
        step(NUM_CH'($urandom), '0, '0, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_words", total_words, 0);
        chk("midrst_corr", corrected_errors, 0);
        chk("midrst_dbl", double_errors, 0);
        chk("midrst_sat", sat, 0);
        chk("midrst_ack", snap_ack, 0);
        a0 = ack_cnt;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        idle(4);
        chk("midrst_no_ack", ack_cnt - a0, 0);
        read_exp(0, 0, 0, 0, 0);
        idle(2);

`ifdef ECC_PERF_IRQ_EN
        thresh = 8'd4;
        for (int k = 0; k < 4; k++) begin
            step(5'b01000, 5'b01000, '0, 1'b0, 1'b0);
            if (k == 2) chk("irq_below", irq, 0);
        end
        chk("irq_at_4th", irq, 0);
        idle(1);
        chk("irq_set", irq, 1);
        idle(3);
        chk("irq_sticky", irq, 1);
        snap(1'b1, '0, '0, '0);
        chk("irq_cleared", irq, 0);
        read_exp(3, 4, 4, 0, 0);
        idle(2);
        thresh = '0;
`endif

        idle(3);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ecc_perf_counters_mc.md
ECC_PERF_COUNTERS_MC -- requirements
Module: ecc_perf_counters_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent ECC channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: counter width in bits (8..64).
REQ-003 SHALL derive localparam CH_W = max(1, clog2(NUM_CH)).
REQ-004 SHALL have port clk  in  1  single clock; all flops on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port valid  in  NUM_CH  per-channel decoded word strobe.
REQ-007 SHALL have port single_error  in  NUM_CH  per-channel corrected single-bit error flag.
REQ-008 SHALL have port double_error  in  NUM_CH  per-channel detected double-bit error flag.
REQ-009 SHALL have port snap_req  in  1  snapshot request pulse.
REQ-010 SHALL have port snap_clr  in  1  clear live counters with the snapshot; sampled with snap_req.
REQ-011 SHALL have port rd_ch  in  CH_W  channel select for the snapshot read.
REQ-012 SHALL have port snap_ack  out  1  one-cycle snapshot-complete pulse.
REQ-013 SHALL have port total_words  out  CNT_W  snapshot word count of channel rd_ch.
REQ-014 SHALL have port corrected_errors  out  CNT_W  snapshot single-error count of rd_ch.
REQ-015 SHALL have port double_errors  out  CNT_W  snapshot double-error count of rd_ch.
REQ-016 SHALL have port sat  out  1  sticky flag: some live counter has saturated.

Function
REQ-017 SHALL keep three live counters per channel: words, corrected, double.
REQ-018 SHALL increment words[i] in any cycle where valid[i]=1.
REQ-019 SHALL increment double[i] when valid[i]&double_error[i], and corrected[i] when valid[i]&single_error[i]&~double_error[i] (double wins).
REQ-020 SHALL ignore error flags when valid[i]=0.
REQ-021 SHALL saturate every counter at all-ones; it never wraps; saturation sets sat.
REQ-022 SHALL run a snapshot FSM with states IDLE, COPY, ACK; IDLE->COPY on snap_req, COPY->ACK unconditionally, ACK->IDLE unconditionally.
REQ-023 SHALL latch snap_clr when snap_req is accepted in IDLE and ignore snap_req in COPY/ACK.
REQ-024 SHALL, on the edge ending COPY, load all shadow registers from the pre-update live values.
REQ-025 SHALL, on that same edge with latched clr=1, set each live counter to 0 plus that cycle's increment and clear sat; no event is lost or double-counted.
REQ-026 SHALL assert snap_ack only during ACK (snap_req at cycle T -> snap_ack at cycle T+2).
REQ-027 SHALL register the read outputs from shadow[rd_ch] with 1-cycle latency; rd_ch >= NUM_CH reads zero.
REQ-028 SHALL leave the shadow registers unchanged outside COPY.

Reset
REQ-029 SHALL asynchronously clear all live counters, shadows, read outputs, sat, and snap_ack to 0 and force FSM to IDLE.
REQ-030 SHALL abandon an in-flight snapshot on reset mid-COPY/ACK; no snap_ack after release.

Configuration
REQ-031 SHALL compile threshold-interrupt logic only when ECC_PERF_IRQ_EN is defined: adds input thresh (CNT_W) and output irq (1).
REQ-032 SHALL, with ECC_PERF_IRQ_EN, set sticky irq when any live corrected[i] >= thresh and thresh != 0; irq clears only on reset or a snapshot with clr.
REQ-033 SHALL, without ECC_PERF_IRQ_EN, have no thresh/irq ports and identical other behaviour.

Structure
REQ-034 SHALL place the FSM state enum (IDLE/COPY/ACK) and the counter-triple struct type in package ecc_perf_pkg.
REQ-035 SHALL implement one saturating counter in sub-module ecc_sat_counter (params W; inputs inc, clr; outputs cnt, sat), instantiated 3*NUM_CH times.

Verification
REQ-036 SHALL cover: ch0 10 valid words, 3 single, 2 double, 1 single+double -> snapshot rd_ch=0 reads 10/3/3.
REQ-037 SHALL cover: CNT_W=8, 300 valid on ch1 -> words[1]=255, sat=1, no wrap.
REQ-038 SHALL cover: snap_req+snap_clr with valid=1 on ch2 during COPY -> shadow holds pre-value, live words[2]=1 afterwards.
REQ-039 SHALL cover: snap_req held 3 cycles -> exactly one snap_ack, at T+2.
REQ-040 SHALL cover: reset asserted during COPY -> all outputs 0 immediately, FSM IDLE, no snap_ack.
REQ-041 SHALL cover, with ECC_PERF_IRQ_EN: thresh=4, 4 singles on ch3 -> irq=1 on the edge after the 4th; snapshot with clr -> irq=0.
